// File: rtl/dct4_stream.sv
// Streaming 4-point integer DCT: gathers four signed samples, applies the forward
// or inverse transform per block, and emits the four results serially.
module dct4_stream #(
  parameter int IN_W      = 8,
  parameter int INV_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_data,
  input  logic                   s_mode,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [IN_W+2:0] m_data,
  output logic [1:0]             m_idx,
  output logic                   m_mode,
  output logic                   m_last
);

  localparam int OUT_W = IN_W + 3;
  localparam logic signed [OUT_W-1:0] RND = OUT_W'((1 << INV_SHIFT) >> 1);

  logic signed [IN_W-1:0]  x [4];
  logic [1:0]              g_cnt;
  logic                    g_full;
  logic                    g_mode;
  logic signed [OUT_W-1:0] bank [4];
  logic [1:0]              o_cnt;
  logic                    o_valid;
  logic                    in_hs;
  logic                    out_hs;
  logic                    xfer;
  logic signed [OUT_W-1:0] xe  [4];
  logic signed [OUT_W-1:0] fwd [4];
  logic signed [OUT_W-1:0] inv [4];
  logic signed [OUT_W-1:0] tr  [4];

  // A gathered block moves to the output bank when the bank is empty or its last beat leaves now.
  always_comb begin
    out_hs  = o_valid && m_ready;
    xfer    = g_full && (!o_valid || (out_hs && o_cnt == 2'd3));
    s_ready = !g_full || xfer;
    in_hs   = s_valid && s_ready;
  end

  assign m_valid = o_valid;
  assign m_data  = bank[o_cnt];
  assign m_idx   = o_cnt;
  assign m_last  = (o_cnt == 2'd3);

  // Three guard bits hold the worst-case magnitude of 6 * 2^(IN_W-1) in either direction.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xe[i] = {{3{x[i][IN_W-1]}}, x[i]};
    end
    fwd[0] = xe[0] + xe[1] + xe[2] + xe[3];
    fwd[1] = (xe[0] <<< 1) + xe[1] - xe[2] - (xe[3] <<< 1);
    fwd[2] = xe[0] - xe[1] - xe[2] + xe[3];
    fwd[3] = xe[0] - (xe[1] <<< 1) + (xe[2] <<< 1) - xe[3];
    inv[0] = xe[0] + (xe[1] <<< 1) + xe[2] + xe[3];
    inv[1] = xe[0] + xe[1] - xe[2] - (xe[3] <<< 1);
    inv[2] = xe[0] - xe[1] - xe[2] + (xe[3] <<< 1);
    inv[3] = xe[0] - (xe[1] <<< 1) + xe[2] - xe[3];
    for (int i = 0; i < 4; i++) begin
      tr[i] = g_mode ? ((inv[i] + RND) >>> INV_SHIFT) : fwd[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_cnt  <= '0;
      g_full <= 1'b0;
      g_mode <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x[i] <= '0;
      end
    end else begin
      if (in_hs) begin
        x[g_cnt] <= s_data;
        g_cnt    <= g_cnt + 2'd1;
        if (g_cnt == 2'd0) begin
          g_mode <= s_mode;
        end
      end
      if (in_hs && g_cnt == 2'd3) begin
        g_full <= 1'b1;
      end else if (xfer) begin
        g_full <= 1'b0;
      end
    end
  end

  // A transfer coinciding with the final beat restarts the bank with no idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cnt   <= '0;
      o_valid <= 1'b0;
      m_mode  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bank[i] <= '0;
      end
    end else if (xfer) begin
      o_cnt   <= '0;
      o_valid <= 1'b1;
      m_mode  <= g_mode;
      for (int i = 0; i < 4; i++) begin
        bank[i] <= tr[i];
      end
    end else if (out_hs) begin
      o_cnt <= o_cnt + 2'd1;
      if (o_cnt == 2'd3) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct4_stream.sv
// Self-checking bench for dct4_stream: random blocks compared with a matrix model,
// plus latency, back-to-back, backpressure and reset scenarios.
module tb_dct4_stream;

  localparam int IN_W  = 8;
  localparam int OUT_W = IN_W + 3;
  localparam int C [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

  logic clk = 1'b0;
  logic rst, s_valid, s_ready, s_mode, m_valid, m_ready, m_mode, m_last;
  logic signed [IN_W-1:0]  s_data;
  logic signed [OUT_W-1:0] m_data, m_data2;
  logic [1:0] m_idx, m_idx2;
  logic s_ready2, m_valid2, m_mode2, m_last2;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_acc = 0;
  int stalls = 0;
  int ctl_diff = 0;
  int obs_data[$], obs_data2[$], obs_idx[$], obs_mode[$], obs_last[$], obs_cyc[$], obs_sready[$];
  int exp_data[$], exp_data2[$], exp_mode[$];

  dct4_stream #(.IN_W(IN_W), .INV_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_mode(m_mode), .m_last(m_last)
  );

  dct4_stream #(.IN_W(IN_W), .INV_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_mode(s_mode),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_idx(m_idx2), .m_mode(m_mode2), .m_last(m_last2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Record every handshake mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && s_ready) last_acc = cyc;
      if (m_valid && m_ready) begin
        obs_data.push_back(int'(m_data));
        obs_data2.push_back(int'(m_data2));
        obs_idx.push_back(int'(m_idx));
        obs_mode.push_back(int'(m_mode));
        obs_last.push_back(int'(m_last));
        obs_cyc.push_back(cyc);
        obs_sready.push_back(int'(s_ready));
      end
      if ({s_ready2, m_valid2, m_idx2, m_mode2, m_last2} !== {s_ready, m_valid, m_idx, m_mode, m_last})
        ctl_diff++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Reference: forward X = C*x, inverse y = C^T*X then round-half-up shift.
  function automatic int ref_coef(input int xs [4], input bit inverse, input int shift, input int k);
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += inverse ? C[i][k] * xs[i] : C[k][i] * xs[i];
    if (inverse) acc = (acc + ((1 << shift) >> 1)) >>> shift;
    return acc;
  endfunction

  function automatic int rs();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic clear_queues();
    obs_data.delete(); obs_data2.delete(); obs_idx.delete(); obs_mode.delete();
    obs_last.delete(); obs_cyc.delete(); obs_sready.delete();
    exp_data.delete(); exp_data2.delete(); exp_mode.delete();
  endtask

  task automatic push(input int d, input bit md);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d[7:0];
    s_mode  = md;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = s_ready;
      n++;
      @(posedge clk);
      #1;
    end
    stalls += n - 1;
    checks++;
    if (!acc) begin
      fails++;
      $display("[TB] FAIL push_timeout accepted=%0b required=1", acc);
    end
  endtask

  task automatic send_block(input int a, input int b, input int c, input int d, input bit md, input int gap_max);
    int xs [4];
    xs = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      exp_data.push_back(ref_coef(xs, md, 0, k));
      exp_data2.push_back(ref_coef(xs, md, 2, k));
      exp_mode.push_back(int'(md));
    end
    for (int i = 0; i < 4; i++) begin
      push(xs[i], (i == 0) ? md : ~md);
      if (gap_max > 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (obs_data.size() < n && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks += 7;
    if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid got %b exp 0", m_valid); end
    if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_s_ready got %b exp 1", s_ready); end
    if (m_data !== '0) begin fails++; $display("[TB] FAIL reset_m_data got %0d exp 0", m_data); end
    if (m_data2 !== '0) begin fails++; $display("[TB] FAIL reset_m_data2 got %0d exp 0", m_data2); end
    if (m_mode !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_mode got %b exp 0", m_mode); end
    if (m_idx !== 2'd0) begin fails++; $display("[TB] FAIL reset_m_idx got %0d exp 0", m_idx); end
    if (m_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_last got %b exp 0", m_last); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    clear_queues();
    m_ready = 1'b1;
    send_block(5, 10, 20, 0, 1'b0, 0);
    s_valid = 1'b0;
    wait_beats(4);
    checks++;
    if (obs_data.size() != 4) begin fails++; $display("[TB] FAIL fwd_count got %0d exp 4", obs_data.size()); end
    if (obs_cyc.size() > 0) begin
      checks++;
      if (obs_cyc[0] - last_acc != 2) begin
        fails++; $display("[TB] FAIL fwd_latency got %0d exp 2", obs_cyc[0] - last_acc);
      end
    end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks += 5;
      if (obs_data[i] != exp_data[i]) begin fails++; $display("[TB] FAIL fwd_data[%0d] got %0d exp %0d", i, obs_data[i], exp_data[i]); end
      if (obs_data2[i] != exp_data2[i]) begin fails++; $display("[TB] FAIL fwd_data2[%0d] got %0d exp %0d", i, obs_data2[i], exp_data2[i]); end
      if (obs_idx[i] != i % 4) begin fails++; $display("[TB] FAIL fwd_idx[%0d] got %0d exp %0d", i, obs_idx[i], i % 4); end
      if (obs_mode[i] != exp_mode[i]) begin fails++; $display("[TB] FAIL fwd_mode[%0d] got %0d exp %0d", i, obs_mode[i], exp_mode[i]); end
      if (obs_last[i] != int'(i % 4 == 3)) begin fails++; $display("[TB] FAIL fwd_last[%0d] got %0d exp %0d", i, obs_last[i], int'(i % 4 == 3)); end
    end
  endtask

  task automatic test_inverse();
    clear_queues();
    m_ready = 1'b1;
    send_block(4, 0, 0, 0, 1'b1, 0);
    send_block(3, 0, 0, 0, 1'b1, 0);
    send_block(rs(), rs(), rs(), rs(), 1'b1, 0);
    s_valid = 1'b0;
    wait_beats(12);
    checks++;
    if (obs_data.size() != 12) begin fails++; $display("[TB] FAIL inv_count got %0d exp 12", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks += 5;
      if (obs_data[i] != exp_data[i]) begin fails++; $display("[TB] FAIL inv_data[%0d] got %0d exp %0d", i, obs_data[i], exp_data[i]); end
      if (obs_data2[i] != exp_data2[i]) begin fails++; $display("[TB] FAIL inv_data2[%0d] got %0d exp %0d", i, obs_data2[i], exp_data2[i]); end
      if (obs_idx[i] != i % 4) begin fails++; $display("[TB] FAIL inv_idx[%0d] got %0d exp %0d", i, obs_idx[i], i % 4); end
      if (obs_mode[i] != exp_mode[i]) begin fails++; $display("[TB] FAIL inv_mode[%0d] got %0d exp %0d", i, obs_mode[i], exp_mode[i]); end
      if (obs_last[i] != int'(i % 4 == 3)) begin fails++; $display("[TB] FAIL inv_last[%0d] got %0d exp %0d", i, obs_last[i], int'(i % 4 == 3)); end
    end
  endtask

  task automatic test_extremes();
    clear_queues();
    m_ready = 1'b1;
    send_block(-128, -128, -128, -128, 1'b0, 0);
    send_block(127, -128, 127, -128, 1'b0, 0);
    send_block(-128, -128, -128, -128, 1'b1, 0);
    send_block(127, -128, 127, -128, 1'b1, 0);
    s_valid = 1'b0;
    wait_beats(16);
    checks++;
    if (obs_data.size() != 16) begin fails++; $display("[TB] FAIL ext_count got %0d exp 16", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks += 4;
      if (obs_data[i] != exp_data[i]) begin fails++; $display("[TB] FAIL ext_data[%0d] got %0d exp %0d", i, obs_data[i], exp_data[i]); end
      if (obs_data2[i] != exp_data2[i]) begin fails++; $display("[TB] FAIL ext_data2[%0d] got %0d exp %0d", i, obs_data2[i], exp_data2[i]); end
      if (obs_mode[i] != exp_mode[i]) begin fails++; $display("[TB] FAIL ext_mode[%0d] got %0d exp %0d", i, obs_mode[i], exp_mode[i]); end
      if (obs_idx[i] != i % 4) begin fails++; $display("[TB] FAIL ext_idx[%0d] got %0d exp %0d", i, obs_idx[i], i % 4); end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    stalls = 0;
    m_ready = 1'b1;
    send_block(rs(), rs(), rs(), rs(), 1'b0, 0);
    send_block(rs(), rs(), rs(), rs(), 1'b1, 0);
    send_block(rs(), rs(), rs(), rs(), 1'b0, 0);
    s_valid = 1'b0;
    wait_beats(12);
    checks += 2;
    if (stalls != 0) begin fails++; $display("[TB] FAIL b2b_stalls got %0d exp 0", stalls); end
    if (obs_data.size() != 12) begin fails++; $display("[TB] FAIL b2b_count got %0d exp 12", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks += 4;
      if (obs_data[i] != exp_data[i]) begin fails++; $display("[TB] FAIL b2b_data[%0d] got %0d exp %0d", i, obs_data[i], exp_data[i]); end
      if (obs_data2[i] != exp_data2[i]) begin fails++; $display("[TB] FAIL b2b_data2[%0d] got %0d exp %0d", i, obs_data2[i], exp_data2[i]); end
      if (obs_idx[i] != i % 4) begin fails++; $display("[TB] FAIL b2b_idx[%0d] got %0d exp %0d", i, obs_idx[i], i % 4); end
      if (obs_mode[i] != exp_mode[i]) begin fails++; $display("[TB] FAIL b2b_mode[%0d] got %0d exp %0d", i, obs_mode[i], exp_mode[i]); end
      if (i > 0) begin
        checks++;
        if (obs_cyc[i] != obs_cyc[i-1] + 1) begin fails++; $display("[TB] FAIL b2b_gap[%0d] got %0d exp %0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    m_ready = 1'b0;
    send_block(rs(), rs(), rs(), rs(), 1'b1, 0);
    send_block(rs(), rs(), rs(), rs(), 1'b0, 0);
    s_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks += 4;
      if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_s_ready got %b exp 0", s_ready); end
      if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_m_valid got %b exp 1", m_valid); end
      if (m_idx !== 2'd0) begin fails++; $display("[TB] FAIL bp_hold_idx got %0d exp 0", m_idx); end
      if (int'(m_data) != exp_data[0]) begin fails++; $display("[TB] FAIL bp_hold_data got %0d exp %0d", m_data, exp_data[0]); end
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_beats(8);
    checks++;
    if (obs_data.size() != 8) begin fails++; $display("[TB] FAIL bp_count got %0d exp 8", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks += 4;
      if (obs_data[i] != exp_data[i]) begin fails++; $display("[TB] FAIL bp_data[%0d] got %0d exp %0d", i, obs_data[i], exp_data[i]); end
      if (obs_mode[i] != exp_mode[i]) begin fails++; $display("[TB] FAIL bp_mode[%0d] got %0d exp %0d", i, obs_mode[i], exp_mode[i]); end
      if (obs_idx[i] != i % 4) begin fails++; $display("[TB] FAIL bp_idx[%0d] got %0d exp %0d", i, obs_idx[i], i % 4); end
      if (obs_sready[i] != int'(i >= 3)) begin fails++; $display("[TB] FAIL bp_s_ready_beat[%0d] got %0d exp %0d", i, obs_sready[i], int'(i >= 3)); end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    m_ready = 1'b1;
    send_block(rs(), rs(), rs(), rs(), 1'b1, 0);
    push(rs(), 1'b0);
    push(rs(), 1'b0);
    s_valid = 1'b0;
    checks += 2;
    if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL rmid_pre_valid got %b exp 1", m_valid); end
    if (m_idx !== 2'd1) begin fails++; $display("[TB] FAIL rmid_pre_idx got %0d exp 1", m_idx); end
    rst = 1'b1;
    #1;
    checks += 5;
    if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL rmid_m_valid got %b exp 0", m_valid); end
    if (m_data !== '0) begin fails++; $display("[TB] FAIL rmid_m_data got %0d exp 0", m_data); end
    if (m_idx !== 2'd0) begin fails++; $display("[TB] FAIL rmid_m_idx got %0d exp 0", m_idx); end
    if (m_mode !== 1'b0) begin fails++; $display("[TB] FAIL rmid_m_mode got %b exp 0", m_mode); end
    if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL rmid_s_ready got %b exp 1", s_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_queues();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (obs_data.size() != 0) begin fails++; $display("[TB] FAIL rmid_spurious got %0d exp 0", obs_data.size()); end
    send_block(rs(), rs(), rs(), rs(), 1'($urandom_range(0, 1)), 0);
    s_valid = 1'b0;
    wait_beats(4);
    checks++;
    if (obs_data.size() != 4) begin fails++; $display("[TB] FAIL rmid_count got %0d exp 4", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks += 3;
      if (obs_data[i] != exp_data[i]) begin fails++; $display("[TB] FAIL rmid_data[%0d] got %0d exp %0d", i, obs_data[i], exp_data[i]); end
      if (obs_mode[i] != exp_mode[i]) begin fails++; $display("[TB] FAIL rmid_mode[%0d] got %0d exp %0d", i, obs_mode[i], exp_mode[i]); end
      if (obs_idx[i] != i % 4) begin fails++; $display("[TB] FAIL rmid_idx[%0d] got %0d exp %0d", i, obs_idx[i], i % 4); end
    end
  endtask

  task automatic test_random();
    bit done;
    clear_queues();
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 5; b++) send_block(rs(), rs(), rs(), rs(), 1'($urandom_range(0, 1)), 2);
        s_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    wait_beats(20);
    checks += 2;
    if (obs_data.size() != 20) begin fails++; $display("[TB] FAIL rnd_count got %0d exp 20", obs_data.size()); end
    if (ctl_diff != 0) begin fails++; $display("[TB] FAIL rnd_ctl_agree got %0d exp 0", ctl_diff); end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks += 5;
      if (obs_data[i] != exp_data[i]) begin fails++; $display("[TB] FAIL rnd_data[%0d] got %0d exp %0d", i, obs_data[i], exp_data[i]); end
      if (obs_data2[i] != exp_data2[i]) begin fails++; $display("[TB] FAIL rnd_data2[%0d] got %0d exp %0d", i, obs_data2[i], exp_data2[i]); end
      if (obs_idx[i] != i % 4) begin fails++; $display("[TB] FAIL rnd_idx[%0d] got %0d exp %0d", i, obs_idx[i], i % 4); end
      if (obs_mode[i] != exp_mode[i]) begin fails++; $display("[TB] FAIL rnd_mode[%0d] got %0d exp %0d", i, obs_mode[i], exp_mode[i]); end
      if (obs_last[i] != int'(i % 4 == 3)) begin fails++; $display("[TB] FAIL rnd_last[%0d] got %0d exp %0d", i, obs_last[i], int'(i % 4 == 3)); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_mode  = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
